// File: rtl/eth_arp_recv_frame.sv
// GMII receive-side ARP parser: preamble/SFD hunt, Ethernet + ARP field filtering.
// Optional CRC-32 check of the received FCS is enabled by defining ARP_RX_CRC_CHECK_EN.
module eth_arp_recv_frame #(
    parameter logic [47:0] LOCAL_MAC = 48'h0007EDAC6233,
    parameter logic [31:0] LOCAL_IP  = 32'hC0A80002,
    parameter logic [10:0] MAX_LEN   = 11'd1518
) (
    input  logic        gmii_rx_clk,
    input  logic        rst,
    input  logic [7:0]  gmii_rx_data,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic        arp_valid,
    output logic [15:0] arp_opcode,
    output logic [47:0] arp_src_mac,
    output logic [31:0] arp_src_ip,
    output logic        frm_drop
);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_HDR, S_ARP, S_TAIL, S_CHK, S_WAIT} state_t;

    state_t      r_state, w_next;
    logic [10:0] r_cnt;
    logic        r_sfd, r_rej, r_not_local, r_not_bcast;
    logic [7:0]  r_op_lo, r_sha_op;
    logic [47:0] r_sha, r_out_mac;
    logic [31:0] r_spa, r_out_ip;
    logic        r_arp_valid, r_frm_drop;
    logic        w_take, w_mis, w_nl, w_nb, w_crc_ok, w_accept;
    logic [47:0] w_mac_shift;
    logic [31:0] w_ip_shift;
    logic [1:0]  w_ip_idx;

    assign w_take      = gmii_rx_dv && (r_state == S_HDR || r_state == S_ARP || r_state == S_TAIL);
    assign w_mac_shift = LOCAL_MAC << {r_cnt[2:0], 3'b000};
    // TPA bytes sit at 38..41, so the low two count bits are offset by 2
    assign w_ip_idx    = 2'(r_cnt[1:0] + 2'd2);
    assign w_ip_shift  = LOCAL_IP << {w_ip_idx, 3'b000};

`ifdef ARP_RX_CRC_CHECK_EN
    logic [31:0] r_crc;

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c ^ {24'h0, d};
        for (int unsigned k = 0; k < 8; k++)
            v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    always_ff @(posedge gmii_rx_clk) begin
        if (rst)
            r_crc <= '1;
        else if (r_state == S_PRE)
            r_crc <= '1;
        else if (w_take)
            r_crc <= crc_next(r_crc, gmii_rx_data);
    end

    assign w_crc_ok = (r_crc == 32'hDEBB20E3);
`else
    assign w_crc_ok = 1'b1;
`endif

    assign w_accept = !r_rej && !(r_not_local && r_not_bcast) && (r_cnt >= 11'd64) &&
                      (r_cnt <= MAX_LEN) && w_crc_ok;

    always_comb begin
        w_mis = 1'b0;
        w_nl  = 1'b0;
        w_nb  = 1'b0;
        if (r_state == S_HDR) begin
            if (r_cnt < 11'd6) begin
                w_nl = (gmii_rx_data != w_mac_shift[47:40]);
                w_nb = (gmii_rx_data != 8'hFF);
            end else if (r_cnt == 11'd12) begin
                w_mis = (gmii_rx_data != 8'h08);
            end else if (r_cnt == 11'd13) begin
                w_mis = (gmii_rx_data != 8'h06);
            end
        end else if (r_state == S_ARP) begin
            case (r_cnt)
                11'd14, 11'd17, 11'd20: w_mis = (gmii_rx_data != 8'h00);
                11'd15:                 w_mis = (gmii_rx_data != 8'h01);
                11'd16:                 w_mis = (gmii_rx_data != 8'h08);
                11'd18:                 w_mis = (gmii_rx_data != 8'h06);
                11'd19:                 w_mis = (gmii_rx_data != 8'h04);
                11'd21:                 w_mis = !(gmii_rx_data == 8'h01 || gmii_rx_data == 8'h02);
                11'd38, 11'd39, 11'd40, 11'd41: w_mis = (gmii_rx_data != w_ip_shift[31:24]);
                default:                w_mis = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (gmii_rx_dv && gmii_rx_data == 8'h55) w_next = S_PRE;
            S_PRE: begin
                if (!gmii_rx_dv)                 w_next = S_IDLE;
                else if (gmii_rx_data == 8'hD5)  w_next = S_HDR;
                else if (gmii_rx_data != 8'h55)  w_next = S_WAIT;
            end
            S_HDR: begin
                if (!gmii_rx_dv)                 w_next = S_IDLE;
                else if (gmii_rx_er)             w_next = S_WAIT;
                else if (r_cnt == 11'd13)        w_next = S_ARP;
            end
            S_ARP: begin
                if (!gmii_rx_dv)                 w_next = S_IDLE;
                else if (gmii_rx_er)             w_next = S_WAIT;
                else if (r_cnt == 11'd41)        w_next = S_TAIL;
            end
            S_TAIL: begin
                if (!gmii_rx_dv)                 w_next = S_CHK;
                else if (gmii_rx_er)             w_next = S_WAIT;
            end
            // A preamble byte arriving during CHK starts the next frame directly
            S_CHK:  w_next = (gmii_rx_dv && gmii_rx_data == 8'h55) ? S_PRE : S_IDLE;
            S_WAIT: if (!gmii_rx_dv) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_sfd       <= 1'b0;
            r_rej       <= 1'b0;
            r_not_local <= 1'b0;
            r_not_bcast <= 1'b0;
            r_op_lo     <= '0;
            r_sha_op    <= '0;
            r_sha       <= '0;
            r_spa       <= '0;
            r_out_mac   <= '0;
            r_out_ip    <= '0;
            r_arp_valid <= 1'b0;
            r_frm_drop  <= 1'b0;
        end else begin
            r_arp_valid <= 1'b0;
            r_frm_drop  <= 1'b0;
            case (r_state)
                S_PRE: begin
                    r_sfd       <= gmii_rx_dv && (gmii_rx_data == 8'hD5);
                    r_cnt       <= '0;
                    r_rej       <= 1'b0;
                    r_not_local <= 1'b0;
                    r_not_bcast <= 1'b0;
                end
                S_HDR, S_ARP: if (!gmii_rx_dv) r_frm_drop <= 1'b1;
                S_CHK: begin
                    if (w_accept) begin
                        r_arp_valid <= 1'b1;
                        r_op_lo     <= r_sha_op;
                        r_out_mac   <= r_sha;
                        r_out_ip    <= r_spa;
                    end else begin
                        r_frm_drop  <= 1'b1;
                    end
                end
                S_WAIT: if (!gmii_rx_dv && r_sfd) r_frm_drop <= 1'b1;
                default: ;
            endcase
            if (w_take) begin
                r_cnt       <= (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
                r_rej       <= r_rej | w_mis;
                r_not_local <= r_not_local | w_nl;
                r_not_bcast <= r_not_bcast | w_nb;
                if (r_state == S_ARP) begin
                    if (r_cnt == 11'd21)                       r_sha_op <= gmii_rx_data;
                    if (r_cnt >= 11'd22 && r_cnt <= 11'd27)    r_sha <= {r_sha[39:0], gmii_rx_data};
                    if (r_cnt >= 11'd28 && r_cnt <= 11'd31)    r_spa <= {r_spa[23:0], gmii_rx_data};
                end
            end
        end
    end

    assign arp_valid   = r_arp_valid;
    assign frm_drop    = r_frm_drop;
    assign arp_opcode  = {8'h00, r_op_lo};
    assign arp_src_mac = r_out_mac;
    assign arp_src_ip  = r_out_ip;

endmodule

// File: tb/tb_eth_arp_recv_frame.sv
// Directed bench for eth_arp_recv_frame: builds ARP frames with computed FCS and
// checks accept/drop pulses and the captured sender fields.
module tb_eth_arp_recv_frame;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = '0;
    logic        rx_dv = 1'b0;
    logic        rx_er = 1'b0;
    logic        arp_valid, frm_drop;
    logic [15:0] arp_opcode;
    logic [47:0] arp_src_mac;
    logic [31:0] arp_src_ip;

    int checks = 0;
    int errors = 0;
    int n_valid = 0;
    int n_drop  = 0;

    logic [7:0] frm [0:1599];
    int         frm_len;

    eth_arp_recv_frame #(
        .LOCAL_MAC (48'h0007EDAC6233),
        .LOCAL_IP  (32'hC0A80002),
        .MAX_LEN   (11'd1518)
    ) dut (
        .gmii_rx_clk  (clk),
        .rst          (rst),
        .gmii_rx_data (rx_data),
        .gmii_rx_dv   (rx_dv),
        .gmii_rx_er   (rx_er),
        .arp_valid    (arp_valid),
        .arp_opcode   (arp_opcode),
        .arp_src_mac  (arp_src_mac),
        .arp_src_ip   (arp_src_ip),
        .frm_drop     (frm_drop)
    );

    always #4 clk = ~clk;

    always @(negedge clk) begin
        if (arp_valid) n_valid++;
        if (frm_drop)  n_drop++;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] v;
        v = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++)
            v = v[0] ? ((v >> 1) ^ 32'hEDB88320) : (v >> 1);
        return v;
    endfunction

    // Broadcast ARP from 192.168.0.3 / 00:23:CD:76:63:1A, zero padded, FCS appended LSB first
    task automatic build_frame(input logic [7:0] op, input logic [31:0] tpa,
                               input logic [15:0] etype, input int len);
        logic [31:0] crc;
        logic [7:0]  hdr [0:41];
        hdr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h00, 8'h23, 8'hCD, 8'h76, 8'h63, 8'h1A,
                etype[15:8], etype[7:0],
                8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, op,
                8'h00, 8'h23, 8'hCD, 8'h76, 8'h63, 8'h1A,
                8'hC0, 8'hA8, 8'h00, 8'h03,
                8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                tpa[31:24], tpa[23:16], tpa[15:8], tpa[7:0]};
        for (int i = 0; i < len - 4; i++) frm[i] = (i < 42) ? hdr[i] : 8'h00;
        crc = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) crc = crc_upd(crc, frm[i]);
        crc = ~crc;
        frm[len-4] = crc[7:0];
        frm[len-3] = crc[15:8];
        frm[len-2] = crc[23:16];
        frm[len-1] = crc[31:24];
        frm_len = len;
    endtask

    // Drives preamble+SFD+frame, then one dv=0 cycle; er/rst pulse at given byte index
    task automatic drive_frame(input int er_at, input int rst_at);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx_dv = 1'b1; rx_er = 1'b0;
            rx_data = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 0; i < frm_len; i++) begin
            @(negedge clk);
            rx_data = frm[i];
            rx_er = (i == er_at);
            rst = (i == rst_at);
        end
        @(negedge clk);
        rx_dv = 1'b0; rx_er = 1'b0; rst = 1'b0; rx_data = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(3);
        checks++; if (arp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", arp_valid); end
        checks++; if (frm_drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b exp=0", frm_drop); end
        checks++; if (arp_opcode !== 16'h0) begin errors++; $display("FAIL reset_opcode got=%h exp=0000", arp_opcode); end
        checks++; if (arp_src_mac !== 48'h0) begin errors++; $display("FAIL reset_mac got=%h exp=0", arp_src_mac); end
        checks++; if (arp_src_ip !== 32'h0) begin errors++; $display("FAIL reset_ip got=%h exp=0", arp_src_ip); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good;
        int v0, d0;
        v0 = n_valid; d0 = n_drop;
        build_frame(8'h01, 32'hC0A80002, 16'h0806, 64);
        drive_frame(-1, -1);
        @(negedge clk);
        checks++; if (arp_valid !== 1'b0) begin errors++; $display("FAIL good_early got=%b exp=0", arp_valid); end
        @(negedge clk);
        checks++; if (arp_valid !== 1'b1) begin errors++; $display("FAIL good_latency got=%b exp=1", arp_valid); end
        idle(4);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL good_valid_count got=%0d exp=1", n_valid - v0); end
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL good_drop_count got=%0d exp=0", n_drop - d0); end
        checks++; if (arp_opcode !== 16'h0001) begin errors++; $display("FAIL good_opcode got=%h exp=0001", arp_opcode); end
        checks++; if (arp_src_mac !== 48'h0023CD76631A) begin errors++; $display("FAIL good_mac got=%h exp=0023cd76631a", arp_src_mac); end
        checks++; if (arp_src_ip !== 32'hC0A80003) begin errors++; $display("FAIL good_ip got=%h exp=c0a80003", arp_src_ip); end
    endtask

    task automatic test_wrong_tpa;
        int v0, d0;
        v0 = n_valid; d0 = n_drop;
        build_frame(8'h02, 32'hC0A80005, 16'h0806, 64);
        drive_frame(-1, -1);
        idle(5);
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL tpa_drop got=%0d exp=1", n_drop - d0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL tpa_valid got=%0d exp=0", n_valid - v0); end
        checks++; if (arp_opcode !== 16'h0001) begin errors++; $display("FAIL tpa_hold_opcode got=%h exp=0001", arp_opcode); end
        checks++; if (arp_src_ip !== 32'hC0A80003) begin errors++; $display("FAIL tpa_hold_ip got=%h exp=c0a80003", arp_src_ip); end
    endtask

    task automatic test_crc;
        int v0, d0, ev, ed;
        v0 = n_valid; d0 = n_drop;
`ifdef ARP_RX_CRC_CHECK_EN
        ev = 0; ed = 1;
`else
        ev = 1; ed = 0;
`endif
        build_frame(8'h01, 32'hC0A80002, 16'h0806, 64);
        frm[63] = frm[63] ^ 8'h10;
        drive_frame(-1, -1);
        idle(5);
        checks++; if (n_valid - v0 !== ev) begin errors++; $display("FAIL crc_valid got=%0d exp=%0d", n_valid - v0, ev); end
        checks++; if (n_drop - d0 !== ed) begin errors++; $display("FAIL crc_drop got=%0d exp=%0d", n_drop - d0, ed); end
    endtask

    task automatic test_ethertype_and_er;
        int v0, d0;
        v0 = n_valid; d0 = n_drop;
        build_frame(8'h01, 32'hC0A80002, 16'h0800, 64);
        drive_frame(-1, -1);
        idle(5);
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL etype_drop got=%0d exp=1", n_drop - d0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL etype_valid got=%0d exp=0", n_valid - v0); end
        v0 = n_valid; d0 = n_drop;
        build_frame(8'h01, 32'hC0A80002, 16'h0806, 64);
        drive_frame(20, -1);
        idle(5);
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL er_drop got=%0d exp=1", n_drop - d0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL er_valid got=%0d exp=0", n_valid - v0); end
    endtask

    task automatic test_length;
        int v0, d0;
        v0 = n_valid; d0 = n_drop;
        build_frame(8'h01, 32'hC0A80002, 16'h0806, 63);
        drive_frame(-1, -1);
        idle(5);
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL short_drop got=%0d exp=1", n_drop - d0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL short_valid got=%0d exp=0", n_valid - v0); end
        v0 = n_valid; d0 = n_drop;
        build_frame(8'h01, 32'hC0A80002, 16'h0806, 1518);
        drive_frame(-1, -1);
        idle(5);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL maxlen_valid got=%0d exp=1", n_valid - v0); end
        v0 = n_valid; d0 = n_drop;
        build_frame(8'h01, 32'hC0A80002, 16'h0806, 1519);
        drive_frame(-1, -1);
        idle(5);
        checks++; if (n_drop - d0 !== 1) begin errors++; $display("FAIL overlen_drop got=%0d exp=1", n_drop - d0); end
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL overlen_valid got=%0d exp=0", n_valid - v0); end
    endtask

    task automatic test_back_to_back;
        int v0, d0;
        v0 = n_valid; d0 = n_drop;
        build_frame(8'h01, 32'hC0A80002, 16'h0806, 64);
        drive_frame(-1, -1);
        build_frame(8'h02, 32'hC0A80002, 16'h0806, 64);
        drive_frame(-1, -1);
        idle(5);
        checks++; if (n_valid - v0 !== 2) begin errors++; $display("FAIL b2b_valid got=%0d exp=2", n_valid - v0); end
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL b2b_drop got=%0d exp=0", n_drop - d0); end
        checks++; if (arp_opcode !== 16'h0002) begin errors++; $display("FAIL b2b_opcode got=%h exp=0002", arp_opcode); end
    endtask

    task automatic test_rst_mid;
        int v0, d0;
        v0 = n_valid; d0 = n_drop;
        build_frame(8'h01, 32'hC0A80002, 16'h0806, 64);
        drive_frame(-1, 30);
        idle(5);
        checks++; if (n_valid - v0 !== 0) begin errors++; $display("FAIL rstmid_valid got=%0d exp=0", n_valid - v0); end
        checks++; if (n_drop - d0 !== 0) begin errors++; $display("FAIL rstmid_drop got=%0d exp=0", n_drop - d0); end
        checks++; if (arp_src_ip !== 32'h0) begin errors++; $display("FAIL rstmid_ip_cleared got=%h exp=0", arp_src_ip); end
        v0 = n_valid;
        drive_frame(-1, -1);
        idle(5);
        checks++; if (n_valid - v0 !== 1) begin errors++; $display("FAIL rstmid_resume got=%0d exp=1", n_valid - v0); end
        checks++; if (arp_src_ip !== 32'hC0A80003) begin errors++; $display("FAIL rstmid_resume_ip got=%h exp=c0a80003", arp_src_ip); end
    endtask

    initial begin
        test_reset;
        test_good;
        test_wrong_tpa;
        test_crc;
        test_ethertype_and_er;
        test_length;
        test_back_to_back;
        test_rst_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
